// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: local word RAM for the low half of the address
// space, and a posted-write FIFO draining MMIO stores to a peripheral bus.
`timescale 1ns/1ps
module data_mem_ctrl #(
   parameter int AW         = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] MemAddr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] MemData,
   output logic        IoValid,
   output logic [7:0]  IoAddr,
   output logic [31:0] IoData,
   input  logic        IoReady,
   output logic        Overflow
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [31:0]   ram_q      [2**AW];
   logic [7:0]    fifo_off_q [FIFO_DEPTH];
   logic [31:0]   fifo_dat_q [FIFO_DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          valid_q, valid_d;

   logic          mmio_s;
   logic [7:0]    offset_s;
   logic [AW-1:0] ram_idx_s;
   logic          ram_we_s;
   logic          status_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          accept_s;
   logic [7:0]    cnt8_s;
   logic [31:0]   rd_data_s;
   logic          unused_s;

   assign mmio_s    = MemAddr[15];
   assign offset_s  = MemAddr[9:2];
   assign ram_idx_s = MemAddr[AW+1:2];
   assign ram_we_s  = MemWrite & ~mmio_s;
   assign status_s  = mmio_s & (offset_s == 8'd0);
   assign push_s    = MemWrite & mmio_s & (offset_s != 8'd0);
   assign pop_s     = valid_q & IoReady;
   assign full_s    = (count_q == CW'(FIFO_DEPTH));
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign accept_s  = push_s & (~full_s | pop_s);
   assign cnt8_s    = 8'(count_q);
   assign unused_s  = ^{MemAddr[14:10], MemAddr[1:0]};

   // Next-state for FIFO pointers, occupancy, valid flag and sticky overflow.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (accept_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case ({accept_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (MemWrite && status_s) begin
         ovf_d = 1'b0;
      end else if (push_s && !accept_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      valid_d = (count_d != CW'(0));
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
      end
   end

   // Storage arrays carry no reset; RAM contents survive Reset.
   always_ff @(posedge Clock) begin
      if (ram_we_s) begin
         ram_q[ram_idx_s] <= WriteData;
      end
      if (accept_s) begin
         fifo_off_q[wr_ptr_q] <= offset_s;
         fifo_dat_q[wr_ptr_q] <= WriteData;
      end
   end

   // Load data mux: RAM is read before any same-edge write lands.
   always_comb begin
      rd_data_s = 32'd0;
      if (!MemRead) begin
         rd_data_s = 32'd0;
      end else if (!mmio_s) begin
         rd_data_s = ram_q[ram_idx_s];
      end else if (offset_s == 8'd0) begin
         rd_data_s = {ovf_q, 23'd0, cnt8_s};
      end else begin
         rd_data_s = 32'd0;
      end
   end

   assign MemData  = rd_data_s;
   assign IoValid  = valid_q;
   assign IoAddr   = valid_q ? fifo_off_q[rd_ptr_q] : 8'd0;
   assign IoData   = valid_q ? fifo_dat_q[rd_ptr_q] : 32'd0;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed scenarios then random traffic
// against an array/queue reference model.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

   localparam int AW    = 10;
   localparam int DEPTH = 4;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] MemAddr = 16'd0;
   logic [31:0] WriteData = 32'd0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] MemData;
   logic        IoValid;
   logic [7:0]  IoAddr;
   logic [31:0] IoData;
   logic        IoReady = 1'b0;
   logic        Overflow;

   data_mem_ctrl #(.AW(AW), .FIFO_DEPTH(DEPTH)) dut (
      .Clock(Clock), .Reset(Reset), .MemAddr(MemAddr), .WriteData(WriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .MemData(MemData),
      .IoValid(IoValid), .IoAddr(IoAddr), .IoData(IoData),
      .IoReady(IoReady), .Overflow(Overflow)
   );

   always #5 Clock = ~Clock;

   int n_chk = 0;
   int n_err = 0;

   // reference model
   logic [31:0] ram_m [int];
   int          m_cnt = 0;
   logic        m_ovf = 1'b0;
   logic [39:0] exp_io_q [$];
   logic [31:0] exp_rd_q [$];

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [15:0] a);
      int off;
      int idx;
      off = (int'(a) >> 2) & 255;
      idx = (int'(a) >> 2) % (1 << AW);
      if (a[15] == 1'b0) return ram_m.exists(idx) ? ram_m[idx] : 32'h0;
      if (off == 0) return {m_ovf, 23'd0, 8'(m_cnt)};
      return 32'd0;
   endfunction

   // One bus cycle: drive, record expectations, advance the model at the edge.
   task automatic cyc(input logic [15:0] a, input logic [31:0] d, input logic w,
                      input logic r, input logic rdy);
      logic pop;
      int   off;
      int   idx;
      MemAddr = a; WriteData = d; MemWrite = w; MemRead = r; IoReady = rdy;
      if (r) exp_rd_q.push_back(model_read(a));
      pop = (m_cnt != 0) && rdy;
      off = (int'(a) >> 2) & 255;
      idx = (int'(a) >> 2) % (1 << AW);
      @(posedge Clock);
      if (w && !a[15]) ram_m[idx] = d;
      if (w && a[15]) begin
         if (off == 0) m_ovf = 1'b0;
         else if (m_cnt < DEPTH || pop) begin
            exp_io_q.push_back({8'(off), d});
            m_cnt++;
         end else m_ovf = 1'b1;
      end
      if (pop) m_cnt--;
      #1;
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) cyc(16'h0000, 32'd0, 1'b0, 1'b0, rdy);
   endtask

   // Monitor: compares every presented output against the scoreboard.
   always @(negedge Clock) begin
      logic [39:0] e;
      chk("io_valid", {39'd0, IoValid}, {39'd0, m_cnt != 0});
      chk("overflow", {39'd0, Overflow}, {39'd0, m_ovf});
      if (MemRead) begin
         if (exp_rd_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL memdata_unexpected: got %h expected none", MemData);
         end else begin
            e = {8'd0, exp_rd_q.pop_front()};
            chk("memdata", {8'd0, MemData}, e);
         end
      end else begin
         chk("memdata_idle", {8'd0, MemData}, 40'd0);
      end
      if (IoValid && IoReady) begin
         if (exp_io_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL io_unexpected: got %h/%h expected none", IoAddr, IoData);
         end else begin
            e = exp_io_q.pop_front();
            chk("io_head", {IoAddr, IoData}, e);
         end
      end
      if (!IoValid) chk("io_empty_zero", {IoAddr, IoData}, 40'd0);
   end

   initial begin
      logic [15:0] a;
      int unsigned op;
      #1;
      chk("rst_valid", {39'd0, IoValid}, 40'd0);
      chk("rst_ovf", {39'd0, Overflow}, 40'd0);
      chk("rst_head", {IoAddr, IoData}, 40'd0);
      @(posedge Clock); @(posedge Clock); #1;
      Reset = 1'b0;

      // RAM write/read, byte-offset ignored, idle read is zero
      cyc(16'h0040, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
      cyc(16'h0040, 32'd0, 1'b0, 1'b1, 1'b0);
      cyc(16'h0042, 32'd0, 1'b0, 1'b1, 1'b0);
      cyc(16'h0040, 32'd0, 1'b0, 1'b0, 1'b0);
      // read-during-write returns old data
      cyc(16'h0010, 32'd1, 1'b1, 1'b0, 1'b0);
      cyc(16'h0010, 32'd2, 1'b1, 1'b1, 1'b0);
      cyc(16'h0010, 32'd0, 1'b0, 1'b1, 1'b0);
      // MMIO drain
      cyc(16'h8004, 32'hA, 1'b1, 1'b0, 1'b0);
      cyc(16'h8008, 32'hB, 1'b1, 1'b0, 1'b0);
      cyc(16'h8000, 32'd0, 1'b0, 1'b1, 1'b0);
      idle(1'b1, 2);
      cyc(16'h8000, 32'd0, 1'b0, 1'b1, 1'b1);
      // overflow and clear
      for (int i = 0; i < 5; i++) cyc(16'h8004, 32'h100 + i, 1'b1, 1'b0, 1'b0);
      cyc(16'h8000, 32'd0, 1'b0, 1'b1, 1'b0);
      cyc(16'h8000, 32'd0, 1'b1, 1'b0, 1'b0);
      idle(1'b1, DEPTH + 1);
      // full with simultaneous pop
      for (int i = 0; i < 4; i++) cyc(16'h8004, 32'h200 + i, 1'b1, 1'b0, 1'b0);
      cyc(16'h800C, 32'h77, 1'b1, 1'b0, 1'b1);
      cyc(16'h8000, 32'd0, 1'b0, 1'b1, 1'b0);
      idle(1'b1, DEPTH + 1);
      // asynchronous reset with queued entries and overflow pending
      for (int i = 0; i < 5; i++) cyc(16'h8010, 32'h300 + i, 1'b1, 1'b0, 1'b0);
      MemWrite = 1'b0; MemRead = 1'b0; IoReady = 1'b0;
      #2 Reset = 1'b1;
      #1;
      chk("async_valid", {39'd0, IoValid}, 40'd0);
      chk("async_ovf", {39'd0, Overflow}, 40'd0);
      m_cnt = 0; m_ovf = 1'b0; exp_io_q.delete();
      @(posedge Clock); #1;
      Reset = 1'b0;
      cyc(16'h0040, 32'd0, 1'b0, 1'b1, 1'b0);

      // random traffic over an initialised RAM window
      for (int i = 0; i < 64; i++) cyc(16'(i << 2), $urandom, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 5);
         if (op <= 2) begin
            a = 16'($urandom) & 16'h7FFF;
            a[11:8] = 4'd0;
         end else begin
            a = 16'h8000 | 16'($urandom & 32'h7C03);
            a[9:2] = (op == 4) ? 8'd0 : 8'($urandom_range(1, 7));
         end
         case (op)
            0, 3:    cyc(a, $urandom, 1'b1, 1'b0, $urandom_range(0, 2) == 0);
            1, 5:    cyc(a, $urandom, 1'b0, 1'b1, $urandom_range(0, 2) == 0);
            2:       cyc(a, $urandom, 1'b1, 1'b1, $urandom_range(0, 2) == 0);
            default: cyc(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 2) == 0);
         endcase
      end
      idle(1'b1, DEPTH + 2);
      chk("io_drained", 40'(exp_io_q.size()), 40'd0);
      chk("rd_drained", 40'(exp_rd_q.size()), 40'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
